// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and constants for the FIFO read-side packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/beat_reg.sv
// ============================================================================
// Module      : beat_reg
// Description : Output beat register with valid/ready hold semantics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_reg #(
    parameter int DATA_W = 128,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              free
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;

    // Free when empty or being drained this cycle, so a new beat can load back-to-back.
    assign free    = !r_valid || m_ready;
    assign m_valid = r_valid;
    assign m_data  = r_data;
    assign m_keep  = r_keep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
            r_keep  <= load_keep;
        end else if (m_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_pack.sv
// ============================================================================
// Module      : fifo_rd_pack
// Description : Packs FWFT FIFO words into RATIO-wide beats with timeout/flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_pack
    import fifo_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       fifo_rdata,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [IN_W*RATIO-1:0] m_data,
    output logic [RATIO-1:0]      m_keep,
    output logic [CNT_W-1:0]      beat_cnt,
    output logic [CNT_W-1:0]      part_cnt
);

    localparam int c_IDX_W  = $clog2(RATIO);
    localparam int c_DATA_W = IN_W * RATIO;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [c_DATA_W-1:0]  r_pack;
    logic [7:0]           r_idle;
    logic                 w_last;
    logic                 w_free;
    logic                 w_timeout;
    logic                 w_load;
    logic [c_DATA_W-1:0]  w_load_data;
    logic [RATIO-1:0]     w_load_keep;
    logic [RATIO-1:0]     w_part_keep;
    logic [c_DATA_W-1:0]  w_full;

    assign w_last = (r_idx == c_IDX_W'(RATIO - 1));
    // Upper word of r_pack is always zero here, so the head word just fills it.
    assign w_full = {fifo_rdata, r_pack[c_DATA_W-IN_W-1:0]};
    // Idle means starved by an empty FIFO; backpressure stalls do not age a partial beat.
    assign w_timeout = (r_idx != '0) && fifo_empty && (r_idle == 8'(TIMEOUT - 1));

    always_comb begin
        w_part_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            w_part_keep[k] = (k < int'(r_idx));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        fifo_ren    = 1'b0;
        w_load      = 1'b0;
        w_load_data = r_pack;
        w_load_keep = w_part_keep;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                fifo_ren = !fifo_empty && (!w_last || w_free);
                if (fifo_ren) begin
                    if (w_last) begin
                        w_load      = 1'b1;
                        w_load_data = w_full;
                        w_load_keep = '1;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end
                if ((w_idx_nxt != '0) && (flush || w_timeout)) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_free) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_pack <= '0;
            r_idle <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            if (w_load) begin
                r_pack <= '0;
            end else if (fifo_ren) begin
                r_pack[int'(r_idx)*IN_W +: IN_W] <= fifo_rdata;
            end
            if (w_load || fifo_ren || (r_idx == '0) || (r_state != ST_FILL)) begin
                r_idle <= '0;
            end else if (fifo_empty) begin
                r_idle <= r_idle + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            part_cnt <= '0;
        end else if (m_valid && m_ready) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (m_keep != '1) begin
                part_cnt <= part_cnt + CNT_W'(1);
            end
        end
    end

    beat_reg #(
        .DATA_W (c_DATA_W),
        .KEEP_W (RATIO)
    ) u_beat_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .load_data (w_load_data),
        .load_keep (w_load_keep),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .free      (w_free)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_pack.sv
// ============================================================================
// Module      : tb_fifo_rd_pack
// Description : Directed and randomized self-checking bench for fifo_rd_pack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_pack;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  fifo_rdata;
    logic         fifo_empty;
    logic         fifo_ren;
    logic         flush;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic [3:0]   m_keep;
    logic [15:0]  beat_cnt;
    logic [15:0]  part_cnt;

    fifo_rd_pack u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .beat_cnt   (beat_cnt),
        .part_cnt   (part_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0]  q[$];
    logic [127:0] rx_data[$];
    logic [3:0]   rx_keep[$];
    int           n_cmp = 0;
    int           n_err = 0;
    bit           rand_mode = 1'b0;
    bit           stall = 1'b0;
    int           stall_run = 0;
    int           low_run = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        fifo_empty = (q.size() == 0) || stall;
        fifo_rdata = (q.size() > 0) ? q[0] : 32'h0;
    endtask

    // One cycle: sample at negedge, apply pop/capture just after posedge.
    task automatic tick();
        logic         s_ren;
        logic         s_hs;
        logic [127:0] s_data;
        logic [3:0]   s_keep;
        @(negedge clk);
        s_ren  = fifo_ren;
        s_hs   = m_valid && m_ready;
        s_data = m_data;
        s_keep = m_keep;
        @(posedge clk);
        #1;
        if (s_ren && q.size() > 0) void'(q.pop_front());
        if (s_hs) begin
            rx_data.push_back(s_data);
            rx_keep.push_back(s_keep);
        end
        if (rand_mode) begin
            stall     = (stall_run < 3) && ($urandom_range(0, 2) == 0);
            stall_run = stall ? stall_run + 1 : 0;
            m_ready   = !((low_run < 4) && ($urandom_range(0, 2) == 0));
            low_run   = m_ready ? 0 : low_run + 1;
        end
        drive();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_rx(input int n, input int bound, input string tag);
        int c;
        c = 0;
        while (rx_data.size() < n && c < bound) begin
            tick();
            c++;
        end
        chk(tag, 128'(rx_data.size() >= n), 128'(1));
    endtask

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        drive();
    endtask

    initial begin
        int base;
        int n_words;
        int n_bad;
        int t_start;
        logic [127:0] hold_d;
        logic [31:0]  wv;

        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        drive();
        for (int i = 1; i <= 8; i++) push(32'(i));
        @(negedge clk);
        chk("rst_ren",   128'(fifo_ren), 128'(0));
        chk("rst_valid", 128'(m_valid),  128'(0));
        chk("rst_data",  m_data,         128'(0));
        chk("rst_keep",  128'(m_keep),   128'(0));
        chk("rst_beat",  128'(beat_cnt), 128'(0));
        chk("rst_part",  128'(part_cnt), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_ren", 128'(fifo_ren), 128'(0));

        // Two full beats from a preloaded FIFO
        wait_rx(2, 40, "t1_rx");
        chk("t1_b0",   rx_data[0], 128'h00000004_00000003_00000002_00000001);
        chk("t1_k0",   128'(rx_keep[0]), 128'hF);
        chk("t1_b1",   rx_data[1], 128'h00000008_00000007_00000006_00000005);
        chk("t1_k1",   128'(rx_keep[1]), 128'hF);
        chk("t1_beat", 128'(beat_cnt), 128'd2);
        chk("t1_part", 128'(part_cnt), 128'd0);

        // Timeout partial beat
        push(32'hA); push(32'hB); push(32'hC);
        t_start = 0;
        while (rx_data.size() < 3 && t_start < 60) begin
            tick();
            t_start++;
        end
        chk("t2_late", 128'(t_start >= 19), 128'(1));
        chk("t2_rx",   128'(rx_data.size()), 128'd3);
        chk("t2_data", rx_data[2], 128'h00000000_0000000C_0000000B_0000000A);
        chk("t2_keep", 128'(rx_keep[2]), 128'h7);
        chk("t2_part", 128'(part_cnt), 128'd1);
        chk("t2_beat", 128'(beat_cnt), 128'd3);

        // Backpressure hold with 12 words queued
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(32'h100 + 32'(i));
        ticks(5);
        hold_d = m_data;
        ticks(15);
        chk("t3_valid", 128'(m_valid), 128'(1));
        chk("t3_hold",  m_data, hold_d);
        chk("t3_data",  m_data, 128'h00000103_00000102_00000101_00000100);
        chk("t3_qleft", 128'(q.size()), 128'd5);
        @(negedge clk);
        chk("t3_ren",   128'(fifo_ren), 128'(0));
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_rx(6, 40, "t3_rx");
        chk("t3_b0", rx_data[3], 128'h00000103_00000102_00000101_00000100);
        chk("t3_b1", rx_data[4], 128'h00000107_00000106_00000105_00000104);
        chk("t3_b2", rx_data[5], 128'h0000010B_0000010A_00000109_00000108);
        chk("t3_beat", 128'(beat_cnt), 128'd6);
        chk("t3_part", 128'(part_cnt), 128'd1);

        // Flush of a single word, then flush with nothing packed
        push(32'h55);
        ticks(3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_rx(7, 10, "t4_rx");
        chk("t4_keep", 128'(rx_keep[6]), 128'h1);
        chk("t4_data", rx_data[6], 128'h55);
        chk("t4_part", 128'(part_cnt), 128'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ticks(20);
        chk("t4_nobeat", 128'(rx_data.size()), 128'd7);
        chk("t4_beat",   128'(beat_cnt), 128'd7);

        // Reset in the middle of a beat
        for (int i = 0; i < 4; i++) push(32'h200 + 32'(i));
        ticks(2);
        rst_n = 1'b0;
        q.delete();
        drive();
        @(negedge clk);
        chk("t5_valid", 128'(m_valid),  128'(0));
        chk("t5_data",  m_data,         128'(0));
        chk("t5_keep",  128'(m_keep),   128'(0));
        chk("t5_beat",  128'(beat_cnt), 128'(0));
        chk("t5_part",  128'(part_cnt), 128'(0));
        chk("t5_ren",   128'(fifo_ren), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(i));
        wait_rx(8, 20, "t5_rx");
        chk("t5_full",  rx_data[7], 128'h00000303_00000302_00000301_00000300);
        chk("t5_kfull", 128'(rx_keep[7]), 128'hF);
        chk("t5_beat1", 128'(beat_cnt), 128'd1);
        chk("t5_part0", 128'(part_cnt), 128'd0);

        // Random stalls on both sides, 1002 words then flush
        base = rx_data.size();
        for (int i = 0; i < 1002; i++) q.push_back(32'h1000 + 32'(i));
        rand_mode = 1'b1;
        drive();
        t_start = 0;
        while (q.size() > 0 && t_start < 8000) begin
            tick();
            t_start++;
        end
        chk("t6_drain", 128'(q.size()), 128'd0);
        rand_mode = 1'b0;
        stall     = 1'b0;
        m_ready   = 1'b1;
        drive();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_rx(base + 251, 50, "t6_rx");
        n_words = 0;
        n_bad   = 0;
        for (int b = base; b < rx_data.size(); b++) begin
            for (int k = 0; k < 4; k++) begin
                if (rx_keep[b][k]) begin
                    wv = rx_data[b][k*32 +: 32];
                    if (wv !== 32'h1000 + 32'(n_words)) n_bad++;
                    n_words++;
                end
            end
        end
        chk("t6_order", 128'(n_bad), 128'd0);
        chk("t6_words", 128'(n_words), 128'd1002);
        chk("t6_lastk", 128'(rx_keep[rx_keep.size()-1]), 128'h3);
        chk("t6_beat",  128'(beat_cnt), 128'd252);
        chk("t6_part",  128'(part_cnt), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
